cons_uart_rx: RTL
=================

# cons_uart_rx

Console serial receiver for the KS10 system. Deserializes the asynchronous console line (`conRXD` at the top level) into 8-bit characters and buffers them in a 4-entry FIFO for the console interface, which pops them with a one-cycle read strobe. It is the stage directly upstream of the console register logic. Line errors (framing, overrun, optional parity) are reported through sticky flags.

## Interface
Parameters:
- `CLKFRQ`, 50000000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bits/s. Oversample divider DIV = CLKFRQ/(BAUD*16), truncated; DIV must be at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial line, idle high, asynchronous to `clk`.
- `rxREAD`  in  1  pop strobe from the console interface, one cycle per character.
- `errCLR`  in  1  clears all sticky error flags.
- `rxDATA`  out  8  FIFO head character, bit 0 = first data bit received.
- `rxEMPTY`  out  1  FIFO empty.
- `rxFULL`  out  1  FIFO holds 4 characters.
- `rxFERR`  out  1  sticky framing error.
- `rxOVR`  out  1  sticky overrun.
- `rxPERR`  out  1  sticky parity error. Present only with `CONS_UART_PARITY_EN`.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1.
- Tick generator: counter 0..DIV-1 produces a one-cycle `tick` at terminal count. The counter runs freely, and the state machine restarts the phase counter on a start edge.
- Phase counter: 4-bit, 0..15, advances on `tick`.
- States:
  - BREAK: reset state. Waits for synchronized `rxd`=1, then goes to IDLE. A line held low through reset never produces a frame.
  - IDLE: synchronized `rxd`=0 clears the tick and phase counters, then goes to START.
  - START: at phase 7 (mid-bit), re-samples `rxd`. 1 means false start and returns to IDLE. 0 goes to DATA.
  - DATA: samples at each subsequent phase-7 point, 8 times, shifting LSB-first. Then goes to PARITY if enabled, otherwise STOP.
  - PARITY: samples the parity bit at phase 7 and checks even parity over data plus parity bit.
  - STOP: samples at phase 7.
    - 1: push the character and go to IDLE.
    - 0: set `rxFERR`, discard the character, and go to BREAK.
- FIFO: 4 entries, 2-bit read and write pointers plus a count, with first-word fall-through. `rxDATA` is valid whenever `rxEMPTY`=0.
- Push to a full FIFO with no pop in the same cycle: the character is dropped, `rxOVR` is set, and contents are unchanged.
- Push and pop in the same cycle: both take effect, including when full (no overrun) and when count=1.
- `rxREAD` while empty: ignored, pointers unchanged.
- `errCLR` in the same cycle as a new error event: the set wins.
- Parity error: the character is still pushed, and `rxPERR` is set.

## Timing
- Reset values:
  - `rxDATA`=8'h00, `rxEMPTY`=1, `rxFULL`=0, `rxFERR`=0, `rxOVR`=0, `rxPERR`=0.
  - State=BREAK, and all counters 0.
- Reset is asynchronous assert and synchronous release. Release is provided by the top-level reset block.
- Start detection: 2 clocks of synchronizer latency after the falling edge, plus 1 clock to enter START.
- A character is accepted at the stop-bit mid-sample: about 9.5 bit times after the start edge (10.5 with parity).
- `rxEMPTY` falls and `rxDATA` becomes valid on the clock edge following the stop sample.
- Pop: `rxDATA` shows the next entry and `rxEMPTY`/`rxFULL` update on the clock edge after `rxREAD`.
- Error flags assert on the edge following the offending sample. `errCLR` takes effect on the next edge.
- Start-bit validation rejects low pulses shorter than 8 ticks.
- Reset mid-frame: the partial character is discarded, the FIFO is emptied, and the receiver returns to BREAK.

## Configuration
- `CONS_UART_PARITY_EN` defined:
  - frame = start, 8 data, even parity, 1 stop (11 bits);
  - PARITY state and `rxPERR` port exist.
- Not defined:
  - frame = start, 8 data, 1 stop (10 bits);
  - PARITY state and `rxPERR` port are absent, and no parity logic is generated.

## Test plan
Bench parameters: CLKFRQ=1600000, BAUD=10000, giving DIV=10 and 160 clocks per bit.
1. Send 8'h55 with a valid stop bit -> `rxEMPTY` falls ~1525 clocks after the start edge with `rxDATA`=8'h55. Pulsing `rxREAD` -> `rxEMPTY`=1 next cycle.
2. Low glitch of 40 clocks on idle line -> no push, FSM back in IDLE, no flags set. Then a valid 8'hA3 -> received as 8'hA3.
3. Five back-to-back characters 8'h01..8'h05, no reads -> `rxFULL`=1, `rxOVR`=1 after the fifth. Four pops return 01, 02, 03, 04, then `rxEMPTY`=1.
4. FIFO full with `rxREAD` coincident with the push of 8'h06 -> no overrun, count stays 4, and the final pop order ends with 8'h06.
5. 8'hA5 with stop bit 0, line held low 3 bit times -> `rxFERR`=1, FIFO empty, no frame until line goes high. `errCLR` -> `rxFERR`=0. Next 8'h3C received correctly.
6. `rst` driven low mid-data-bit of 8'hFF -> all outputs at reset values immediately. After release, 8'h12 is received cleanly. With the macro defined, 8'h07 sent with parity bit 0 -> `rxDATA`=8'h07 and `rxPERR`=1.

Source files
------------

// File: rtl/cons_uart_rx.sv
// Console serial receiver: 16x oversampled 8-bit deserializer feeding a 4-entry fall-through FIFO.
// Optional even parity is compiled in with `define CONS_UART_PARITY_EN.
module cons_uart_rx #(
   parameter int unsigned CLKFRQ = 50000000,
   parameter int unsigned BAUD   = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       rxREAD,
   input  logic       errCLR,
   output logic [7:0] rxDATA,
   output logic       rxEMPTY,
   output logic       rxFULL,
   output logic       rxFERR,
`ifdef CONS_UART_PARITY_EN
   output logic       rxPERR,
`endif
   output logic       rxOVR
);

   localparam int unsigned DIV  = CLKFRQ / (BAUD * 16);
   localparam int unsigned DIVW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int unsigned CNTW = 3;

`ifdef CONS_UART_PARITY_EN
   typedef enum logic [2:0] {ST_BREAK, ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
   typedef enum logic [2:0] {ST_BREAK, ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

   state_t            state;
   logic [1:0]        sync_q;
   logic              rxd_s;
   logic [DIVW-1:0]   tick_cnt;
   logic [3:0]        phase;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;
   logic              push;
   logic              ferr_set;
`ifdef CONS_UART_PARITY_EN
   logic              perr_set;
`endif
   logic              tick;
   logic              sample;

   logic [7:0]        mem [4];
   logic [1:0]        wr_ptr;
   logic [1:0]        rd_ptr;
   logic [CNTW-1:0]   count;
   logic [CNTW-1:0]   count_next;
   logic              pop;
   logic              wr;
   logic              ovr_evt;

   assign rxd_s  = sync_q[1];
   assign tick   = (tick_cnt == DIVW'(DIV - 1));
   assign sample = tick && (phase == 4'd7);
   assign rxDATA = mem[rd_ptr];

   // Two-flop synchronizer, idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= 2'b11;
      else      sync_q <= {sync_q[0], rxd};
   end

   // Receive FSM with its tick/phase counters; push and error events are registered pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_BREAK;
         tick_cnt <= '0;
         phase    <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         push     <= 1'b0;
         ferr_set <= 1'b0;
`ifdef CONS_UART_PARITY_EN
         perr_set <= 1'b0;
`endif
      end else begin
         push     <= 1'b0;
         ferr_set <= 1'b0;
`ifdef CONS_UART_PARITY_EN
         perr_set <= 1'b0;
`endif
         tick_cnt <= tick ? '0 : tick_cnt + DIVW'(1);
         if (tick) phase <= phase + 4'd1;
         case (state)
            ST_BREAK: if (rxd_s) state <= ST_IDLE;
            ST_IDLE: begin
               if (!rxd_s) begin
                  tick_cnt <= '0;
                  phase    <= '0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               bit_cnt <= '0;
               if (sample) state <= rxd_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               if (sample) begin
                  shift   <= {rxd_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
`ifdef CONS_UART_PARITY_EN
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
`else
                  if (bit_cnt == 3'd7) state <= ST_STOP;
`endif
               end
            end
`ifdef CONS_UART_PARITY_EN
            ST_PARITY: begin
               if (sample) begin
                  perr_set <= ^{shift, rxd_s};
                  state    <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (sample) begin
                  if (rxd_s) begin
                     push  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     ferr_set <= 1'b1;
                     state    <= ST_BREAK;
                  end
               end
            end
            default: state <= ST_BREAK;
         endcase
      end
   end

   // FIFO control: a pop frees the slot a simultaneous push needs when full.
   always_comb begin
      pop        = rxREAD && (count != '0);
      wr         = push && ((count != CNTW'(4)) || pop);
      ovr_evt    = push && (count == CNTW'(4)) && !pop;
      count_next = count;
      if (wr && !pop)      count_next = count + CNTW'(1);
      else if (!wr && pop) count_next = count - CNTW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rxEMPTY <= 1'b1;
         rxFULL  <= 1'b0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= shift;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         count   <= count_next;
         rxEMPTY <= (count_next == '0);
         rxFULL  <= (count_next == CNTW'(4));
      end
   end

   // Sticky error flags; a new event outranks a clear in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxFERR <= 1'b0;
         rxOVR  <= 1'b0;
`ifdef CONS_UART_PARITY_EN
         rxPERR <= 1'b0;
`endif
      end else begin
         if (ferr_set)    rxFERR <= 1'b1;
         else if (errCLR) rxFERR <= 1'b0;
         if (ovr_evt)     rxOVR  <= 1'b1;
         else if (errCLR) rxOVR  <= 1'b0;
`ifdef CONS_UART_PARITY_EN
         if (perr_set)    rxPERR <= 1'b1;
         else if (errCLR) rxPERR <= 1'b0;
`endif
      end
   end

endmodule
